usart_frame_recv: RTL and testbench

//  UART receive end of the 5-byte parameter frame: byte 1 address, byte 2 mode select, bytes 3-5 D[23:16], D[15:8], D[7:0].

---
 rtl/usart_frame_recv.sv | 242 ++++++++++++++++++++++++
 tb/tb_usart_frame_recv.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usart_frame_recv.sv
`default_nettype none
// ============================================================================
// Module      : usart_frame_recv
// Description : 8N1 UART receiver feeding a 5-byte parameter frame assembler
//               (address, mode select, 24-bit data). Checks framing, header
//               bytes and inter-byte gaps. Publishes a complete frame
//               atomically with a one-cycle frame_valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module usart_frame_recv #(
  parameter logic [15:0] BPS_CNT = 16'd434,
  parameter int unsigned GAP_CNT = 20 * BPS_CNT
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        uart_rxd,
  output logic [1:0]  Adress,
  output logic [5:0]  Mod_SEL,
  output logic [23:0] D,
  output logic        frame_valid,
  output logic        frame_err
);

  localparam logic [15:0] C_HALF_M1 = (BPS_CNT >> 1) - 16'd1;
  localparam logic [15:0] C_FULL_M1 = BPS_CNT - 16'd1;
  localparam logic [31:0] C_GAP_M1  = 32'(GAP_CNT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Input path
  logic [2:0]  sync_q;
  logic        rxd_s;
  logic        fall;

  // Bit FSM
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_no_q, bit_no_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        byte_done;
  logic        stop_err;

  // Frame assembler
  logic [2:0]  idx_q, idx_d;
  logic [1:0]  sh_adr_q, sh_adr_d;
  logic [5:0]  sh_mod_q, sh_mod_d;
  logic [23:8] sh_d_q, sh_d_d;
  logic [31:0] gap_q, gap_d;
  logic        gap_hit;
  logic [1:0]  adress_q, adress_d;
  logic [5:0]  mod_q, mod_d;
  logic [23:0] d_q, d_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  // Two-flop synchroniser plus a history flop for falling-edge detection
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], uart_rxd};
    end
  end

  assign rxd_s = sync_q[1];
  assign fall  = sync_q[2] & ~sync_q[1];

  // Bit-level receive state machine: single mid-bit sample per bit
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_no_d  = bit_no_q;
    rx_byte_d = rx_byte_q;
    byte_done = 1'b0;
    stop_err  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (fall) begin
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == C_HALF_M1) begin
          cnt_d    = '0;
          bit_no_d = '0;
          // A start bit that is high again at its centre was only a glitch
          state_d  = rxd_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == C_FULL_M1) begin
          cnt_d     = '0;
          rx_byte_d = {rxd_s, rx_byte_q[7:1]};
          bit_no_d  = bit_no_q + 3'd1;
          if (bit_no_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == C_FULL_M1) begin
          cnt_d   = '0;
          // Return to IDLE either way; a stuck-low line produces no new edge
          state_d = S_IDLE;
          if (rxd_s) begin
            byte_done = 1'b1;
          end else begin
            stop_err = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame assembly, header checks and inter-byte gap supervision
  always_comb begin
    idx_d    = idx_q;
    sh_adr_d = sh_adr_q;
    sh_mod_d = sh_mod_q;
    sh_d_d   = sh_d_q;
    gap_d    = gap_q;
    adress_d = adress_q;
    mod_d    = mod_q;
    d_d      = d_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    gap_hit  = 1'b0;

    // A falling edge in the timeout cycle takes precedence over the timeout
    if (fall || byte_done || (idx_q == 3'd0)) begin
      gap_d = '0;
    end else if (state_q == S_IDLE) begin
      if (gap_q == C_GAP_M1) begin
        gap_d   = '0;
        gap_hit = 1'b1;
      end else begin
        gap_d = gap_q + 32'd1;
      end
    end

    if (stop_err) begin
      err_d = 1'b1;
      idx_d = 3'd0;
    end else if (byte_done) begin
      unique case (idx_q)
        3'd0: begin
          if (rx_byte_q[7:2] != 6'd0) begin
            err_d = 1'b1;
          end else begin
            sh_adr_d = rx_byte_q[1:0];
            idx_d    = 3'd1;
          end
        end
        3'd1: begin
          if (rx_byte_q[7:6] != 2'd0) begin
            err_d = 1'b1;
            idx_d = 3'd0;
          end else begin
            sh_mod_d = rx_byte_q[5:0];
            idx_d    = 3'd2;
          end
        end
        3'd2: begin
          sh_d_d[23:16] = rx_byte_q;
          idx_d         = 3'd3;
        end
        3'd3: begin
          sh_d_d[15:8] = rx_byte_q;
          idx_d        = 3'd4;
        end
        3'd4: begin
          // Last byte goes straight to the outputs so the update is atomic
          adress_d = sh_adr_q;
          mod_d    = sh_mod_q;
          d_d      = {sh_d_q[23:8], rx_byte_q};
          valid_d  = 1'b1;
          idx_d    = 3'd0;
        end
        default: idx_d = 3'd0;
      endcase
    end else if (gap_hit) begin
      err_d = 1'b1;
      idx_d = 3'd0;
    end
  end

  // State and data registers for the bit FSM and frame assembler
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_no_q  <= '0;
      rx_byte_q <= '0;
      idx_q     <= '0;
      sh_adr_q  <= '0;
      sh_mod_q  <= '0;
      sh_d_q    <= '0;
      gap_q     <= '0;
      adress_q  <= '0;
      mod_q     <= '0;
      d_q       <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_no_q  <= bit_no_d;
      rx_byte_q <= rx_byte_d;
      idx_q     <= idx_d;
      sh_adr_q  <= sh_adr_d;
      sh_mod_q  <= sh_mod_d;
      sh_d_q    <= sh_d_d;
      gap_q     <= gap_d;
      adress_q  <= adress_d;
      mod_q     <= mod_d;
      d_q       <= d_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign Adress      = adress_q;
  assign Mod_SEL     = mod_q;
  assign D           = d_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_usart_frame_recv.sv
`default_nettype none
// ============================================================================
// Module      : tb_usart_frame_recv
// Description : Self-checking bench for usart_frame_recv with a frame
//               scoreboard (BPS_CNT=8, GAP_CNT=160).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usart_frame_recv;

  localparam int BPS = 8;
  localparam int GAP = 160;
  // Start drive -> stop-bit sample of the same byte: 2 sync clocks, 1 clock
  // into START, half a bit to the start centre, then 8 data + 1 stop bits.
  localparam int STOP_OFS = 2 + 1 + (BPS / 2 - 1) + 9 * BPS;
  // Frame start -> frame_valid: four full bytes, then byte-5 stop sample + 1
  localparam int LAT = 4 * 10 * BPS + STOP_OFS + 1;

  logic        sys_clk;
  logic        sys_rst;
  logic        uart_rxd;
  logic [1:0]  Adress;
  logic [5:0]  Mod_SEL;
  logic [23:0] D;
  logic        frame_valid;
  logic        frame_err;

  typedef struct {
    logic [1:0]  adr;
    logic [5:0]  mod;
    logic [23:0] d;
    int          start;
  } frame_t;

  frame_t sb[$];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;
  int last_err_cyc   = 0;

  logic [1:0]  mdl_adr = '0;
  logic [5:0]  mdl_mod = '0;
  logic [23:0] mdl_d   = '0;

  usart_frame_recv #(
    .BPS_CNT (16'(BPS)),
    .GAP_CNT (GAP)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .uart_rxd    (uart_rxd),
    .Adress      (Adress),
    .Mod_SEL     (Mod_SEL),
    .D           (D),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every frame_valid must match the oldest pushed frame
  always @(negedge sys_clk) begin
    if (sys_rst === 1'b1 && frame_valid === 1'b1) begin
      valid_cnt++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      check_eq("valid_err_excl", 32'(frame_err), 32'd0);
      check_eq("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        frame_t e;
        e = sb.pop_front();
        check_eq("adress", 32'(Adress), 32'(e.adr));
        check_eq("mod_sel", 32'(Mod_SEL), 32'(e.mod));
        check_eq("data", 32'(D), 32'(e.d));
        check_eq("latency", 32'(cyc - e.start), 32'(LAT));
        mdl_adr = e.adr;
        mdl_mod = e.mod;
        mdl_d   = e.d;
      end
    end
    if (sys_rst === 1'b1 && frame_err === 1'b1) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    uart_rxd = v;
    idle(BPS);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  task automatic send_frame(input logic [39:0] f);
    frame_t e;
    e.adr   = f[33:32];
    e.mod   = f[29:24];
    e.d     = f[23:0];
    e.start = cyc;
    sb.push_back(e);
    for (int i = 0; i < 5; i++) send_byte(f[39 - 8 * i -: 8], 1'b1);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_hold(input string tag);
    check_eq({tag, "_adr"}, 32'(Adress), 32'(mdl_adr));
    check_eq({tag, "_mod"}, 32'(Mod_SEL), 32'(mdl_mod));
    check_eq({tag, "_d"}, 32'(D), 32'(mdl_d));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, v0, b4_start, dt;
    sys_rst  = 1'b0;
    uart_rxd = 1'b1;
    idle(4);
    check_eq("rst_adr", 32'(Adress), 32'd0);
    check_eq("rst_mod", 32'(Mod_SEL), 32'd0);
    check_eq("rst_d", 32'(D), 32'd0);
    check_eq("rst_valid", 32'(frame_valid), 32'd0);
    check_eq("rst_err", 32'(frame_err), 32'd0);
    sys_rst = 1'b1;
    idle(10);

    // 1: basic frame
    e0 = err_cnt; v0 = valid_cnt;
    send_frame(40'h01_2A_12_34_56);
    idle(5);
    check_eq("t1_valids", 32'(valid_cnt - v0), 32'd1);
    check_eq("t1_errs", 32'(err_cnt - e0), 32'd0);
    check_hold("t1_out");

    // 2: partial frame, gap timeout, then a fresh frame
    e0 = err_cnt;
    send_byte(8'h01, 1'b1);
    send_byte(8'h2A, 1'b1);
    send_byte(8'h12, 1'b1);
    b4_start = cyc;
    send_byte(8'h34, 1'b1);
    idle(200);
    check_eq("t2_errs", 32'(err_cnt - e0), 32'd1);
    dt = last_err_cyc - (b4_start + STOP_OFS);
    check_eq("t2_gap_time", 32'(dt >= GAP && dt <= GAP + 4), 32'd1);
    check_hold("t2_hold");
    send_frame(40'h02_05_AA_BB_CC);
    idle(5);

    // 3: byte 3 with a low stop bit
    e0 = err_cnt;
    send_byte(8'h01, 1'b1);
    send_byte(8'h2A, 1'b1);
    send_byte(8'h12, 1'b0);
    uart_rxd = 1'b1;
    idle(20);
    check_eq("t3_errs", 32'(err_cnt - e0), 32'd1);
    check_hold("t3_hold");
    send_frame(40'h01_3C_DE_AD_BE);
    idle(5);

    // 4: bad address header, bad mode header, then a good frame
    e0 = err_cnt;
    send_byte(8'h81, 1'b1);
    idle(5);
    check_eq("t4_adr_hdr_err", 32'(err_cnt - e0), 32'd1);
    send_byte(8'h02, 1'b1);
    send_byte(8'hC5, 1'b1);
    idle(5);
    check_eq("t4_mod_hdr_err", 32'(err_cnt - e0), 32'd2);
    check_hold("t4_hold");
    send_frame(40'h03_3F_00_00_01);
    idle(5);

    // 5a: 2-clock low glitch on an idle line
    e0 = err_cnt; v0 = valid_cnt;
    uart_rxd = 1'b0;
    idle(2);
    uart_rxd = 1'b1;
    idle(30);
    check_eq("t5_glitch_errs", 32'(err_cnt - e0), 32'd0);
    check_eq("t5_glitch_valids", 32'(valid_cnt - v0), 32'd0);

    // 5b: asynchronous reset in the middle of byte 4
    send_byte(8'h01, 1'b1);
    send_byte(8'h2A, 1'b1);
    send_byte(8'h12, 1'b1);
    uart_rxd = 1'b0;
    idle(30);
    #2 sys_rst = 1'b0;
    #1;
    check_eq("t5_rst_adr", 32'(Adress), 32'd0);
    check_eq("t5_rst_mod", 32'(Mod_SEL), 32'd0);
    check_eq("t5_rst_d", 32'(D), 32'd0);
    mdl_adr = '0; mdl_mod = '0; mdl_d = '0;
    uart_rxd = 1'b1;
    idle(3);
    sys_rst = 1'b1;
    idle(20);
    check_hold("t5_post_rst");
    send_frame(40'h02_11_C0_FF_EE);
    idle(5);

    // 6: two frames with no idle between them
    v0 = valid_cnt;
    send_frame(40'h01_2A_12_34_56);
    send_frame(40'h03_15_65_43_21);
    idle(5);
    check_eq("t6_valids", 32'(valid_cnt - v0), 32'd2);
    check_eq("t6_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'(5 * 10 * BPS));
    check_hold("t6_out");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
